// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flush sequencing plus MULT/DIV start-busy-done tracking for the 5-stage core.
// Define PIPE_HAZARD_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned DIV_LAT = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        id_jump,
   input  logic        id_md_start,
   input  logic        id_md_is_div,
   input  logic        id_uses_hilo,
   input  logic        ex_dm_r,
   input  logic        ex_gpr_we,
   input  logic [4:0]  ex_wr_reg,
   input  logic        ex_branch_taken,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        md_go,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   // state | meaning
   // IDLE  | MULT/DIV unit free, no result pending
   // BUSY  | operation in flight, cnt holds remaining busy cycles minus one
   // DONE  | result available for one cycle; may restart immediately
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } md_state_t;

   localparam logic [4:0] MUL_LOAD = 5'(MUL_LAT - 1);
   localparam logic [4:0] DIV_LOAD = 5'(DIV_LAT - 1);

   md_state_t  state;
   logic [4:0] cnt;
   logic       rs_hit;
   logic       rt_hit;
   logic       lu;
   logic       mds;
   logic       stall;
   logic       accept;

   assign rs_hit = id_uses_rs & (id_rs == ex_wr_reg);
   assign rt_hit = id_uses_rt & (id_rt == ex_wr_reg);
   assign lu     = ex_dm_r & ex_gpr_we & (ex_wr_reg != 5'd0) & (rs_hit | rt_hit);
   assign mds    = md_busy & (id_md_start | id_uses_hilo);

   // A taken branch squashes the ID instruction, so it overrides any stall.
   assign stall  = ~rst & ~ex_branch_taken & (mds | lu);
   assign accept = ~rst & id_md_start & ~ex_branch_taken & ~lu & (state != ST_BUSY);

   assign pc_en      = ~stall;
   assign ifid_en    = ~stall;
   assign idex_flush = ex_branch_taken | stall;
   assign ifid_flush = ex_branch_taken | (id_jump & ~stall);
   assign md_go      = accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= 5'd0;
         md_busy <= 1'b0;
         md_done <= 1'b0;
      end else begin
         case (state)
            ST_BUSY: begin
               if (cnt == 5'd0) begin
                  state   <= ST_DONE;
                  md_busy <= 1'b0;
                  md_done <= 1'b1;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
            default: begin
               if (accept) begin
                  state   <= ST_BUSY;
                  cnt     <= id_md_is_div ? DIV_LOAD : MUL_LOAD;
                  md_busy <= 1'b1;
                  md_done <= 1'b0;
               end else begin
                  state   <= ST_IDLE;
                  md_busy <= 1'b0;
                  md_done <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= 32'd0;
         flush_q <= 32'd0;
      end else begin
         if (!pc_en && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
         if (ifid_flush && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = 32'd0;
   assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a cycle-level model.
module tb_pipe_hazard_ctrl;
   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs, id_rt, ex_wr_reg;
   logic        id_uses_rs, id_uses_rt, id_jump, id_md_start, id_md_is_div, id_uses_hilo;
   logic        ex_dm_r, ex_gpr_we, ex_branch_taken;
   logic        pc_en, ifid_en, ifid_flush, idex_flush, md_go, md_busy, md_done;
   logic [31:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   // model state: busy cycles still to come, done flag, counters
   int          m_rem;
   bit          m_done;
   logic [31:0] m_s, m_f;
   bit          e_pc, e_ifen, e_iff, e_idf, e_go;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_jump(id_jump), .id_md_start(id_md_start), .id_md_is_div(id_md_is_div),
      .id_uses_hilo(id_uses_hilo), .ex_dm_r(ex_dm_r), .ex_gpr_we(ex_gpr_we),
      .ex_wr_reg(ex_wr_reg), .ex_branch_taken(ex_branch_taken),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .md_go(md_go), .md_busy(md_busy), .md_done(md_done),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic clear_inputs();
      id_rs = 0; id_rt = 0; ex_wr_reg = 0;
      id_uses_rs = 0; id_uses_rt = 0; id_jump = 0; id_md_start = 0; id_md_is_div = 0;
      id_uses_hilo = 0; ex_dm_r = 0; ex_gpr_we = 0; ex_branch_taken = 0;
   endtask

   // Let inputs settle, derive expected outputs from the priority rules, compare everything.
   task automatic settle();
      bit lu, busy, hold;
      #3;
      if (rst) begin
         m_rem = 0; m_done = 0; m_s = 0; m_f = 0;
      end
      lu = ex_dm_r && ex_gpr_we && (ex_wr_reg != 0) &&
           ((id_uses_rs && id_rs == ex_wr_reg) || (id_uses_rt && id_rt == ex_wr_reg));
      busy = (m_rem > 0);
      hold = busy && (id_md_start || id_uses_hilo);
      if (rst) begin
         e_pc = 1; e_ifen = 1; e_iff = ex_branch_taken || id_jump; e_idf = ex_branch_taken; e_go = 0;
      end else if (ex_branch_taken) begin
         e_pc = 1; e_ifen = 1; e_iff = 1; e_idf = 1; e_go = 0;
      end else if (hold || lu) begin
         e_pc = 0; e_ifen = 0; e_iff = 0; e_idf = 1; e_go = 0;
      end else begin
         e_pc = 1; e_ifen = 1; e_iff = id_jump; e_idf = 0; e_go = id_md_start;
      end
      chk1("pc_en", pc_en, e_pc);
      chk1("ifid_en", ifid_en, e_ifen);
      chk1("ifid_flush", ifid_flush, e_iff);
      chk1("idex_flush", idex_flush, e_idf);
      chk1("md_go", md_go, e_go);
      chk1("md_busy", md_busy, busy);
      chk1("md_done", md_done, m_done);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      chk32("stall_cnt", stall_cnt, m_s);
      chk32("flush_cnt", flush_cnt, m_f);
`else
      chk32("stall_cnt", stall_cnt, 32'd0);
      chk32("flush_cnt", flush_cnt, 32'd0);
`endif
   endtask

   task automatic advance();
      @(posedge clk);
      if (!rst) begin
         if (!e_pc && m_s != 32'hFFFF_FFFF) m_s = m_s + 1;
         if (e_iff && m_f != 32'hFFFF_FFFF) m_f = m_f + 1;
         if (e_go) begin
            m_rem = id_md_is_div ? DIV_LAT : MUL_LAT;
            m_done = 0;
         end else if (m_rem > 0) begin
            m_done = (m_rem == 1);
            m_rem--;
         end else begin
            m_done = 0;
         end
      end
      #1;
   endtask

   task automatic load_use();
      ex_dm_r = 1; ex_gpr_we = 1; ex_wr_reg = 5; id_rs = 5; id_uses_rs = 1;
   endtask

   initial begin
      logic [31:0] s0;
      m_rem = 0; m_done = 0; m_s = 0; m_f = 0;
      clear_inputs();
      rst = 1;
      #2;
      settle();
      chk1("rst_busy", md_busy, 1'b0);
      chk1("rst_done", md_done, 1'b0);
      chk1("rst_pc_en", pc_en, 1'b1);
      chk32("rst_stall_cnt", stall_cnt, 32'd0);
      advance();
      rst = 0;
      settle(); advance();

      // load-use stalls for exactly its own cycle
      load_use();
      settle();
      chk1("lu_pc_en", pc_en, 1'b0);
      chk1("lu_ifid_en", ifid_en, 1'b0);
      chk1("lu_idex_flush", idex_flush, 1'b1);
      advance();
      clear_inputs();
      settle();
      chk1("lu_after_pc_en", pc_en, 1'b1);
      advance();
      load_use(); ex_wr_reg = 0; id_rs = 0;
      settle();
      chk1("lu_r0_pc_en", pc_en, 1'b1);
      advance();

      // taken branch beats the stall and blocks a start
      load_use(); ex_branch_taken = 1; id_md_start = 1;
      settle();
      chk1("br_pc_en", pc_en, 1'b1);
      chk1("br_ifid_flush", ifid_flush, 1'b1);
      chk1("br_idex_flush", idex_flush, 1'b1);
      chk1("br_md_go", md_go, 1'b0);
      advance();
      clear_inputs();
      settle();
      chk1("br_still_idle", md_busy, 1'b0);
      advance();

      // DIV followed by MFHI
      s0 = m_s;
      id_md_start = 1; id_md_is_div = 1;
      settle();
      chk1("div_go", md_go, 1'b1);
      advance();
      clear_inputs(); id_uses_hilo = 1;
      for (int i = 1; i <= DIV_LAT; i++) begin
         settle();
         chk1("div_busy", md_busy, 1'b1);
         chk1("div_hilo_stall", pc_en, 1'b0);
         advance();
      end
      settle();
      chk1("div_done", md_done, 1'b1);
      chk1("div_hilo_go", pc_en, 1'b1);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      chk32("div_stall_cnt", stall_cnt - s0, 32'd32);
`endif
      advance();
      clear_inputs();
      settle();
      chk1("div_idle", md_done, 1'b0);
      advance();

      // MULT back-to-back, second start held until DONE
      id_md_start = 1; id_md_is_div = 0;
      settle();
      chk1("mul_go_T", md_go, 1'b1);
      advance();
      for (int i = 1; i <= MUL_LAT; i++) begin
         settle();
         chk1("mul_busy", md_busy, 1'b1);
         chk1("mul_held_go", md_go, 1'b0);
         advance();
      end
      settle();
      chk1("mul_T5_busy", md_busy, 1'b0);
      chk1("mul_T5_done", md_done, 1'b1);
      chk1("mul_T5_go", md_go, 1'b1);
      advance();
      clear_inputs();
      settle();
      chk1("mul_T6_busy", md_busy, 1'b1);
      advance();
      for (int i = 0; i < MUL_LAT + 1; i++) begin settle(); advance(); end

      // reset in the middle of a DIV
      id_md_start = 1; id_md_is_div = 1;
      settle(); advance();
      clear_inputs();
      settle(); advance();
      rst = 1;
      settle();
      chk1("rstmid_busy", md_busy, 1'b0);
      chk1("rstmid_done", md_done, 1'b0);
      advance();
      rst = 0;
      id_md_start = 1; id_md_is_div = 0;
      settle();
      chk1("post_rst_go", md_go, 1'b1);
      advance();
      clear_inputs();
      for (int i = 1; i <= MUL_LAT; i++) begin settle(); advance(); end
      settle();
      chk1("post_rst_done", md_done, 1'b1);
      advance();

      // jump alone, then jump under a load-use stall
      id_jump = 1;
      settle();
      chk1("jmp_ifid_flush", ifid_flush, 1'b1);
      chk1("jmp_idex_flush", idex_flush, 1'b0);
      chk1("jmp_pc_en", pc_en, 1'b1);
      advance();
      load_use();
      settle();
      chk1("jmp_lu_pc_en", pc_en, 1'b0);
      chk1("jmp_lu_ifid_flush", ifid_flush, 1'b0);
      advance();
      clear_inputs();

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         rst             = ($urandom_range(0, 499) == 0);
         id_rs           = 5'($urandom_range(0, 3));
         id_rt           = 5'($urandom_range(0, 3));
         ex_wr_reg       = 5'($urandom_range(0, 3));
         id_uses_rs      = 1'($urandom_range(0, 1));
         id_uses_rt      = 1'($urandom_range(0, 1));
         id_jump         = ($urandom_range(0, 7) == 0);
         id_md_start     = ($urandom_range(0, 7) == 0);
         id_md_is_div    = ($urandom_range(0, 3) == 0);
         id_uses_hilo    = ($urandom_range(0, 5) == 0);
         ex_dm_r         = ($urandom_range(0, 2) == 0);
         ex_gpr_we       = 1'($urandom_range(0, 1));
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         if (rst) begin
            ex_dm_r = 0; id_md_start = 0; id_uses_hilo = 0;
         end
         settle();
         advance();
      end
      rst = 0;
      clear_inputs();
      settle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
